execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
Multi-cycle execute-stage result unit for the 5-phase core. It adds RV32M/RV64M multiply/divide to the execute stage via an iterative radix-2 engine, and holds the phase machine with stall_execute until the result is ready. Non-M ops pass the existing ALU/comparator results (alu_out_pre, jump_state_pre) through single-cycle, as before. All *_em outputs are the execute→memoryaccess pipeline registers.

Parameters:
XLEN, 32, datapath width (32 or 64)
OPLEN, 10, decoded_op width
CNTW, $clog2(XLEN)+1, iteration counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
phase_execute  in  1  execute phase active
muldiv_op_de  in  1  current op is M-extension
funct3_md  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1data_de  in  XLEN  operand 1
rs2data_de  in  XLEN  operand 2
alu_out_pre  in  XLEN  ALU result, non-M ops
jump_state_pre  in  1  comparator/must-jump result
decoded_op_de  in  OPLEN  passthrough
rdsel_de  in  5  passthrough
next_pc_de  in  XLEN  passthrough
stall_execute  out  1  hold execute phase
decoded_op_em  out  OPLEN  registered
rdsel_em  out  5  registered
next_pc_em  out  XLEN  registered
rs2data_em  out  XLEN  registered
alu_out_em  out  XLEN  registered ALU or M result
jump_state_em  out  1  registered; forced 0 for M ops

Behaviour:
- Reset: rst_n, asynchronous, active-high; clock clk. All outputs, state, and counter clear to 0; FSM goes to IDLE. Reset during CALC aborts the operation with no output update.
- FSM: IDLE, CALC, DONE.
- IDLE→CALC: phase_execute & muldiv_op_de. Latches |rs1|, |rs2| (signedness per funct3), the result sign, and funct3. Loads counter = XLEN.
- IDLE→DONE (special cases, no iteration):
  - Divisor 0: quotient = all-ones, remainder = rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all-ones, DIV/REM): quotient = rs1, remainder = 0.
- CALC: one shift-add (mul, 2·XLEN accumulator) or restoring shift-subtract (div) step per cycle; counter decrements. At counter = 1, go to DONE.
- DONE: apply sign correction (two's-complement negate of product, quotient, or remainder). Select the low/high half or quotient/remainder. Return to IDLE.
- stall_execute = phase_execute & muldiv_op_de & (state != DONE), combinational.
  - Normal M op: XLEN+1 stall cycles.
  - Special case: 1 stall cycle.
  - Non-M op: never stalls.
- Pipeline registers load on a clk edge with phase_execute & ~stall_execute; otherwise they hold.
- phase_execute falling while in CALC: abort to IDLE, registers unchanged.
- Sign rules:
  - Remainder takes the sign of the dividend.
  - Quotient is negative iff operand signs differ.
  - MULHSU treats rs2 as unsigned.
- x on operands propagates to the result (no masking).

Optional Feature:
FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a combinational XLEN×XLEN multiplier. The op goes IDLE→DONE with 1 stall cycle. Division is unchanged.
- Undefined: iterative multiply, XLEN+1 stall cycles. Minimal area.

Decomposition:
- core_general.vh gets:
  - M-op funct3 localparams (FUNCT3_MUL … FUNCT3_REMU).
  - FSM state encodings MD_IDLE/MD_CALC/MD_DONE.
  - XLEN and OPLEN, already defined there.
- Sub-module muldiv_iter holds the FSM, counter, and datapath, with start/busy/done/result interface.
- execute_muldiv keeps the stall logic, result mux, and pipeline registers.

Test Plan:
- Non-M op, alu_out_pre=32'hAAAA_AAAA, jump_state_pre=1 → stall never asserts; alu_out_em=AAAA_AAAA, jump_state_em=1 at phase_memoryaccess.
- DIVU 100/7 → stall high 33 cycles, alu_out_em=0000_000E; REMU same operands → 0000_0002; REM -7/2 → FFFF_FFFF; DIV -7/2 → FFFF_FFFD; jump_state_em=0.
- DIVU 5/0 → FFFF_FFFF; REM 5/0 → 0000_0005; DIV 8000_0000/FFFF_FFFF → 8000_0000; all with exactly 1 stall cycle.
- rs1=rs2=FFFF_FFFF: MUL → 0000_0001, MULH → 0000_0000, MULHU → FFFF_FFFE, MULHSU → FFFF_FFFF.
- Assert rst_n=1 mid-CALC (cycle 10 of DIVU) → all *_em=0, stall_execute=0 while reset is held, FSM IDLE. A rerun of the same op afterwards gives the correct result.
- FAST_MUL_EN defined: MUL 0000_1234×0000_0010 → 0001_2340 with 1 stall cycle; DIVU timing unchanged (33 cycles).

Source files
------------

// File: rtl/execute_muldiv_pkg.sv
// Shared constants for the execute-stage multiply/divide unit: datapath widths,
// M-extension funct3 encodings and the iterative engine's state encoding.
// Ports: none (package only).
package execute_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int OPLEN = 10;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_muldiv_if.sv
// Decode->execute inputs and execute->memoryaccess pipeline outputs of the
// execute_muldiv stage, bundled so the stage connects through one port.
// Modports: master drives decode-side signals, slave is the execute stage.
interface execute_muldiv_if #(
  parameter int XLEN  = execute_muldiv_pkg::XLEN,
  parameter int OPLEN = execute_muldiv_pkg::OPLEN
);

  // decode side
  logic             phase_execute;
  logic             muldiv_op_de;
  logic [2:0]       funct3_md;
  logic [XLEN-1:0]  rs1data_de;
  logic [XLEN-1:0]  rs2data_de;
  logic [XLEN-1:0]  alu_out_pre;
  logic             jump_state_pre;
  logic [OPLEN-1:0] decoded_op_de;
  logic [4:0]       rdsel_de;
  logic [XLEN-1:0]  next_pc_de;

  // execute side
  logic             stall_execute;
  logic [OPLEN-1:0] decoded_op_em;
  logic [4:0]       rdsel_em;
  logic [XLEN-1:0]  next_pc_em;
  logic [XLEN-1:0]  rs2data_em;
  logic [XLEN-1:0]  alu_out_em;
  logic             jump_state_em;

  modport master (
    output phase_execute, muldiv_op_de, funct3_md, rs1data_de, rs2data_de,
           alu_out_pre, jump_state_pre, decoded_op_de, rdsel_de, next_pc_de,
    input  stall_execute, decoded_op_em, rdsel_em, next_pc_em, rs2data_em,
           alu_out_em, jump_state_em
  );

  modport slave (
    input  phase_execute, muldiv_op_de, funct3_md, rs1data_de, rs2data_de,
           alu_out_pre, jump_state_pre, decoded_op_de, rdsel_de, next_pc_de,
    output stall_execute, decoded_op_em, rdsel_em, next_pc_em, rs2data_em,
           alu_out_em, jump_state_em
  );

endinterface

// File: rtl/execute_muldiv_iter.sv
// Radix-2 iterative multiply/divide engine: IDLE -> CALC (XLEN steps) -> DONE,
// with divide-by-zero / signed-overflow short cut straight to DONE.
// Ports: clk, rst_n (async, active-high), start_i/kill_i control, funct3_i,
//        rs1_i/rs2_i operands; busy_o (CALC), done_o (DONE), result_o (valid in DONE).
// Build option: FAST_MUL_EN replaces the multiply iterations with a single
//        combinational XLEN x XLEN product latched in IDLE.
module muldiv_iter #(
  parameter int XLEN = execute_muldiv_pkg::XLEN,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  import execute_muldiv_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              neg_q, neg_d;

  // ---------------- operand conditioning ----------------
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_by_zero, div_ovf;

  assign is_div   = funct3_i[2];
  // MULHSU keeps rs2 unsigned; MUL's low half is sign-agnostic so it runs unsigned.
  assign a_signed = (funct3_i == FUNCT3_MULH) || (funct3_i == FUNCT3_MULHSU) ||
                    (funct3_i == FUNCT3_DIV)  || (funct3_i == FUNCT3_REM);
  assign b_signed = (funct3_i == FUNCT3_MULH) ||
                    (funct3_i == FUNCT3_DIV)  || (funct3_i == FUNCT3_REM);
  assign a_neg    = a_signed & rs1_i[XLEN-1];
  assign b_neg    = b_signed & rs2_i[XLEN-1];
  assign abs_a    = a_neg ? -rs1_i : rs1_i;
  assign abs_b    = b_neg ? -rs2_i : rs2_i;

  assign div_by_zero = is_div && (rs2_i == '0);
  assign div_ovf     = is_div && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step;

  // shift-add: conditionally add multiplicand into the upper half, then shift right
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, opb_q});
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // restoring divide: shift the next dividend bit into the remainder and try a subtract
  assign div_trial = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, opb_q};
  assign div_step  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    funct3_d = funct3_q;
    neg_d    = neg_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          funct3_d = funct3_i;
          opb_d    = abs_b;
          acc_d    = {{XLEN{1'b0}}, abs_a};
          cnt_d    = CNTW'(XLEN);
          // remainder follows the dividend; product/quotient follow the sign xor
          neg_d    = (funct3_i[2] && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
          state_d  = MD_CALC;
          // special cases preload {remainder, quotient} unsigned-uncorrected
          if (div_by_zero) begin
            acc_d   = {rs1_i, {XLEN{1'b1}}};
            neg_d   = 1'b0;
            state_d = MD_DONE;
          end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, rs1_i};
            neg_d   = 1'b0;
            state_d = MD_DONE;
          end
`ifdef FAST_MUL_EN
          else if (!funct3_i[2]) begin
            acc_d   = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
            state_d = MD_DONE;
          end
`endif
        end
      end
      MD_CALC: begin
        if (kill_i) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          acc_d = funct3_q[2] ? div_step : mul_step;
          if (cnt_q == CNTW'(1)) state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // ---------------- sign correction and result select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    div_sel  = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fix  = neg_q ? -div_sel : div_sel;
    if (funct3_q[2])                   result_o = div_fix;
    else if (funct3_q == FUNCT3_MUL)   result_o = prod_fix[XLEN-1:0];
    else                               result_o = prod_fix[2*XLEN-1:XLEN];
  end

  assign busy_o = (state_q == MD_CALC);
  assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage result unit: passes ALU/comparator results through in one cycle
// and runs RV32M/RV64M ops on muldiv_iter, stalling the phase machine until done.
// Ports: clk, rst_n (async, active-high), bus (execute_muldiv_if.slave) carrying
//        the *_de inputs, stall_execute and the *_em pipeline registers.
// Build option: FAST_MUL_EN (single-cycle multiply inside muldiv_iter).
module execute_muldiv #(
  parameter int XLEN  = execute_muldiv_pkg::XLEN,
  parameter int OPLEN = execute_muldiv_pkg::OPLEN,
  parameter int CNTW  = $clog2(XLEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  execute_muldiv_if.slave  bus
);
  import execute_muldiv_pkg::*;

  logic            md_start, md_kill, md_busy, md_done;
  logic [XLEN-1:0] md_result;

  assign md_start = bus.phase_execute & bus.muldiv_op_de;
  // leaving the execute phase mid-iteration abandons the op
  assign md_kill  = md_busy & ~bus.phase_execute;

  muldiv_iter #(
    .XLEN (XLEN),
    .CNTW (CNTW)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .kill_i   (md_kill),
    .funct3_i (bus.funct3_md),
    .rs1_i    (bus.rs1data_de),
    .rs2_i    (bus.rs2data_de),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // Held low during reset so the phase machine is not frozen by a half-reset engine.
  assign bus.stall_execute = ~rst_n & md_start & ~md_done;

  logic load_em;
  assign load_em = bus.phase_execute & ~bus.stall_execute;

  logic [OPLEN-1:0] decoded_op_q;
  logic [4:0]       rdsel_q;
  logic [XLEN-1:0]  next_pc_q;
  logic [XLEN-1:0]  rs2data_q;
  logic [XLEN-1:0]  alu_out_q;
  logic             jump_state_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      decoded_op_q <= '0;
      rdsel_q      <= '0;
      next_pc_q    <= '0;
      rs2data_q    <= '0;
      alu_out_q    <= '0;
      jump_state_q <= 1'b0;
    end else if (load_em) begin
      decoded_op_q <= bus.decoded_op_de;
      rdsel_q      <= bus.rdsel_de;
      next_pc_q    <= bus.next_pc_de;
      rs2data_q    <= bus.rs2data_de;
      // an M op only reaches this load in DONE, so md_result is final here
      alu_out_q    <= bus.muldiv_op_de ? md_result : bus.alu_out_pre;
      jump_state_q <= bus.muldiv_op_de ? 1'b0 : bus.jump_state_pre;
    end
  end

  assign bus.decoded_op_em = decoded_op_q;
  assign bus.rdsel_em      = rdsel_q;
  assign bus.next_pc_em    = next_pc_q;
  assign bus.rs2data_em    = rs2data_q;
  assign bus.alu_out_em    = alu_out_q;
  assign bus.jump_state_em = jump_state_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: pass-through, divide, special cases,
// multiply, reset during CALC and phase abort.
module tb_execute_muldiv;

  localparam int XLEN  = 32;
  localparam int OPLEN = 10;
`ifdef FAST_MUL_EN
  localparam int MUL_STALLS = 1;
`else
  localparam int MUL_STALLS = 33;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  execute_muldiv_if #(.XLEN(XLEN), .OPLEN(OPLEN)) bus ();

  execute_muldiv #(.XLEN(XLEN), .OPLEN(OPLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stl;
    string       name;
  } vec_t;

  // Applies one op from a falling edge and holds it until stall drops; the
  // *_em registers have loaded by the time this returns.
  task automatic run_op(input bit md, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] alu, input bit js,
                        output int n_stall);
    @(negedge clk);
    bus.phase_execute  = 1'b1;
    bus.muldiv_op_de   = md;
    bus.funct3_md      = f3;
    bus.rs1data_de     = a;
    bus.rs2data_de     = b;
    bus.alu_out_pre    = alu;
    bus.jump_state_pre = js;
    n_stall = 0;
    #1;
    while (bus.stall_execute === 1'b1 && n_stall <= 100) begin
      n_stall++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    bus.phase_execute = 1'b0;
    bus.muldiv_op_de  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.phase_execute = 1'b1;
    bus.muldiv_op_de  = 1'b1;
    bus.funct3_md     = 3'b101;
    bus.rs1data_de    = 32'd100;
    bus.rs2data_de    = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (bus.stall_execute !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b expected 0", bus.stall_execute);
    end
    vectors++;
    if (bus.alu_out_em !== 32'h0) begin
      miscompares++; $display("FAIL reset_alu_out: got %h expected 00000000", bus.alu_out_em);
    end
    vectors++;
    if ({bus.decoded_op_em, bus.rdsel_em, bus.next_pc_em, bus.rs2data_em, bus.jump_state_em} !== '0) begin
      miscompares++;
      $display("FAIL reset_pipe_regs: got op=%h rd=%h pc=%h rs2=%h js=%b expected all 0",
               bus.decoded_op_em, bus.rdsel_em, bus.next_pc_em, bus.rs2data_em, bus.jump_state_em);
    end
    @(negedge clk);
    bus.phase_execute = 1'b0;
    bus.muldiv_op_de  = 1'b0;
    rst_n = 1'b0;
  endtask

  task automatic test_passthrough();
    int n;
    run_op(1'b0, 3'b000, 32'h1111_2222, 32'h3333_4444, 32'hAAAA_AAAA, 1'b1, n);
    vectors++;
    if (n !== 0) begin
      miscompares++; $display("FAIL nonm_stall_cycles: got %0d expected 0", n);
    end
    vectors++;
    if (bus.alu_out_em !== 32'hAAAA_AAAA) begin
      miscompares++; $display("FAIL nonm_alu_out: got %h expected aaaaaaaa", bus.alu_out_em);
    end
    vectors++;
    if (bus.jump_state_em !== 1'b1) begin
      miscompares++; $display("FAIL nonm_jump_state: got %b expected 1", bus.jump_state_em);
    end
    vectors++;
    if (bus.rs2data_em !== 32'h3333_4444 || bus.rdsel_em !== 5'd9 ||
        bus.next_pc_em !== 32'h0000_0104 || bus.decoded_op_em !== 10'h2A5) begin
      miscompares++;
      $display("FAIL nonm_passthrough: got rs2=%h rd=%0d pc=%h op=%h expected 33334444 9 00000104 2a5",
               bus.rs2data_em, bus.rdsel_em, bus.next_pc_em, bus.decoded_op_em);
    end
  endtask

  task automatic apply_table(input vec_t v[$]);
    int n;
    foreach (v[i]) begin
      run_op(1'b1, v[i].f3, v[i].a, v[i].b, 32'h5A5A_5A5A, 1'b1, n);
      vectors++;
      if (bus.alu_out_em !== v[i].exp) begin
        miscompares++;
        $display("FAIL %s result: got %h expected %h", v[i].name, bus.alu_out_em, v[i].exp);
      end
      vectors++;
      if (n !== v[i].stl) begin
        miscompares++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", v[i].name, n, v[i].stl);
      end
      vectors++;
      if (bus.jump_state_em !== 1'b0) begin
        miscompares++;
        $display("FAIL %s jump_state: got %b expected 0", v[i].name, bus.jump_state_em);
      end
    end
  endtask

  task automatic test_divide();
    vec_t v[$];
    v.push_back('{3'b101, 32'd100,        32'd7, 32'h0000_000E, 33, "DIVU 100/7"});
    v.push_back('{3'b111, 32'd100,        32'd7, 32'h0000_0002, 33, "REMU 100/7"});
    v.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF, 33, "REM -7/2"});
    v.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFD, 33, "DIV -7/2"});
    v.push_back('{3'b100, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 33, "DIV 20/-6"});
    v.push_back('{3'b110, 32'd20, 32'hFFFF_FFFA, 32'h0000_0002, 33, "REM 20/-6"});
    apply_table(v);
  endtask

  task automatic test_div_special();
    vec_t v[$];
    v.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "DIVU 5/0"});
    v.push_back('{3'b110, 32'd5,         32'd0,         32'h0000_0005, 1, "REM 5/0"});
    v.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf"});
    v.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "REM ovf"});
    apply_table(v);
  endtask

  task automatic test_multiply();
    vec_t v[$];
    v.push_back('{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_STALLS, "MUL -1*-1"});
    v.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_STALLS, "MULH -1*-1"});
    v.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALLS, "MULHU max*max"});
    v.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALLS, "MULHSU -1*max"});
    v.push_back('{3'b000, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, MUL_STALLS, "MUL 1234*10"});
    v.push_back('{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, MUL_STALLS, "MULH -2*3"});
    apply_table(v);
  endtask

  task automatic test_reset_mid_calc();
    int n;
    @(negedge clk);
    bus.phase_execute = 1'b1;
    bus.muldiv_op_de  = 1'b1;
    bus.funct3_md     = 3'b101;
    bus.rs1data_de    = 32'd100;
    bus.rs2data_de    = 32'd7;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.stall_execute !== 1'b0) begin
      miscompares++; $display("FAIL midcalc_reset_stall: got %b expected 0", bus.stall_execute);
    end
    vectors++;
    if ({bus.alu_out_em, bus.decoded_op_em, bus.rdsel_em, bus.next_pc_em,
         bus.rs2data_em, bus.jump_state_em} !== '0) begin
      miscompares++;
      $display("FAIL midcalc_reset_regs: got alu=%h op=%h rd=%h pc=%h rs2=%h js=%b expected all 0",
               bus.alu_out_em, bus.decoded_op_em, bus.rdsel_em, bus.next_pc_em,
               bus.rs2data_em, bus.jump_state_em);
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.stall_execute !== 1'b0 || bus.alu_out_em !== 32'h0) begin
      miscompares++;
      $display("FAIL midcalc_reset_held: got stall=%b alu=%h expected 0 00000000",
               bus.stall_execute, bus.alu_out_em);
    end
    @(negedge clk);
    bus.phase_execute = 1'b0;
    bus.muldiv_op_de  = 1'b0;
    rst_n = 1'b0;
    run_op(1'b1, 3'b101, 32'd100, 32'd7, 32'h0, 1'b0, n);
    vectors++;
    if (bus.alu_out_em !== 32'h0000_000E || n !== 33) begin
      miscompares++;
      $display("FAIL rerun_after_reset: got %h in %0d stalls expected 0000000e in 33",
               bus.alu_out_em, n);
    end
  endtask

  task automatic test_phase_abort();
    int n;
    run_op(1'b0, 3'b000, 32'h0, 32'h0, 32'h5555_1234, 1'b1, n);
    @(negedge clk);
    bus.phase_execute = 1'b1;
    bus.muldiv_op_de  = 1'b1;
    bus.funct3_md     = 3'b100;
    bus.rs1data_de    = 32'd100;
    bus.rs2data_de    = 32'd7;
    repeat (5) @(negedge clk);
    bus.phase_execute = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (bus.alu_out_em !== 32'h5555_1234 || bus.jump_state_em !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_hold: got alu=%h js=%b expected 55551234 1",
               bus.alu_out_em, bus.jump_state_em);
    end
    bus.muldiv_op_de = 1'b0;
    run_op(1'b1, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b1, n);
    vectors++;
    if (bus.alu_out_em !== 32'hFFFF_FFFD || n !== 33) begin
      miscompares++;
      $display("FAIL after_abort_div: got %h in %0d stalls expected fffffffd in 33",
               bus.alu_out_em, n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    run_op(1'b1, 3'b111, 32'd1000, 32'd33, 32'h0, 1'b0, n);
    vectors++;
    if (bus.alu_out_em !== 32'h0000_000A) begin
      miscompares++; $display("FAIL b2b_remu: got %h expected 0000000a", bus.alu_out_em);
    end
    run_op(1'b0, 3'b000, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, n);
    vectors++;
    if (bus.alu_out_em !== 32'hDEAD_BEEF || n !== 0 || bus.jump_state_em !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_nonm: got %h js=%b in %0d stalls expected deadbeef 0 in 0",
               bus.alu_out_em, bus.jump_state_em, n);
    end
  endtask

  initial begin
    bus.phase_execute  = 1'b0;
    bus.muldiv_op_de   = 1'b0;
    bus.funct3_md      = 3'b000;
    bus.rs1data_de     = '0;
    bus.rs2data_de     = '0;
    bus.alu_out_pre    = '0;
    bus.jump_state_pre = 1'b0;
    bus.decoded_op_de  = 10'h2A5;
    bus.rdsel_de       = 5'd9;
    bus.next_pc_de     = 32'h0000_0104;

    test_reset();
    test_passthrough();
    test_divide();
    test_div_special();
    test_multiply();
    test_reset_mid_calc();
    test_phase_abort();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
